// File: rtl/approx_mul_arbiter_pkg.sv
// Shared constants for the approximate-multiplier arbiter.
// Mode selector encodings and requester ID width.
package approx_mul_arbiter_pkg;

    localparam logic [1:0] MODE_PER_REQ = 2'b00;
    localparam logic [1:0] FORCE_APPROX = 2'b01;
    localparam logic [1:0] FORCE_EXACT  = 2'b10;

    localparam int ID_W = 1;

endpackage

// File: rtl/approx_mul_arbiter_hybrid_mul_core.sv
// Combinational hybrid multiplier: full product or upper-half
// product shifted into the top N bits.
module hybrid_mul_core #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           approx,
    output logic [2*N-1:0] p
);

    logic [2*N-1:0] exact_p;
    logic [N-1:0]   hi_p;

    // Select between the full product and the truncated upper-half product
    always_comb begin
        exact_p = (2*N)'(a) * (2*N)'(b);
        hi_p    = N'(a[N-1:N/2]) * N'(b[N-1:N/2]);
        p       = approx ? {hi_p, {N{1'b0}}} : exact_p;
    end

endmodule

// File: rtl/approx_mul_arbiter.sv
// Two-requester round-robin arbiter feeding a shared 2-stage
// hybrid multiplier pipeline with saturating usage counters.
module approx_mul_arbiter
    import approx_mul_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    input  logic [1:0]       req_approx,
    input  logic [1:0]       mode_cfg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_p,
    output logic             out_id,
    output logic             out_approx,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] exact_cnt,
    output logic [CNT_W-1:0] approx_cnt
);

    logic            ptr_q, ptr_d;
    logic            s1_valid_q, s1_valid_d;
    logic [N-1:0]    s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [ID_W-1:0] s1_id_q, s1_id_d;
    logic            s1_mode_q, s1_mode_d;
    logic            s2_valid_q, s2_valid_d;
    logic [2*N-1:0]  s2_p_q, s2_p_d;
    logic [ID_W-1:0] s2_id_q, s2_id_d;
    logic            s2_mode_q, s2_mode_d;
    logic [CNT_W-1:0] exact_cnt_q, exact_cnt_d;
    logic [CNT_W-1:0] approx_cnt_q, approx_cnt_d;

    logic [1:0]      grant;
    logic            s1_load, s2_load;
    logic            accept, fire;
    logic [ID_W-1:0] acc_id;
    logic            acc_mode;
    logic [2*N-1:0]  mul_p;

    hybrid_mul_core #(.N(N)) u_mul (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .approx (s1_mode_q),
        .p      (mul_p)
    );

    // Stage enables, round-robin grant and accept-time mode resolution
    always_comb begin
        s2_load = s1_valid_q & (~s2_valid_q | out_ready);
        s1_load = ~s1_valid_q | s2_load;
        grant   = req_valid;
        if (&req_valid) grant = ptr_q ? 2'b10 : 2'b01;
        req_ready = rst ? 2'b00 : (grant & {2{s1_load}});
        accept  = |(req_valid & req_ready);
        acc_id  = ID_W'(req_ready[1]);
        case (mode_cfg)
            FORCE_APPROX: acc_mode = 1'b1;
            FORCE_EXACT:  acc_mode = 1'b0;
            default:      acc_mode = req_approx[acc_id];
        endcase
        fire = s2_valid_q & out_ready;
    end

    // Next-state for pointer and both pipeline stages
    always_comb begin
        ptr_d      = accept ? ~acc_id : ptr_q;
        s1_valid_d = s1_load ? accept : s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s1_mode_d  = s1_mode_q;
        if (accept) begin
            s1_a_d    = acc_id[0] ? req_a1 : req_a0;
            s1_b_d    = acc_id[0] ? req_b1 : req_b0;
            s1_id_d   = acc_id;
            s1_mode_d = acc_mode;
        end
        s2_valid_d = s2_load | (s2_valid_q & ~out_ready);
        s2_p_d     = s2_p_q;
        s2_id_d    = s2_id_q;
        s2_mode_d  = s2_mode_q;
        if (s2_load) begin
            s2_p_d    = mul_p;
            s2_id_d   = s1_id_q;
            s2_mode_d = s1_mode_q;
        end
    end

    // Saturating completion counters; clear wins over increment
    always_comb begin
        exact_cnt_d  = exact_cnt_q;
        approx_cnt_d = approx_cnt_q;
        if (clr_cnt) begin
            exact_cnt_d  = '0;
            approx_cnt_d = '0;
        end else if (fire) begin
            if (s2_mode_q) begin
                if (approx_cnt_q != '1) approx_cnt_d = approx_cnt_q + CNT_W'(1);
            end else begin
                if (exact_cnt_q != '1) exact_cnt_d = exact_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_id_q      <= '0;
            s1_mode_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_p_q       <= '0;
            s2_id_q      <= '0;
            s2_mode_q    <= 1'b0;
            exact_cnt_q  <= '0;
            approx_cnt_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_id_q      <= s1_id_d;
            s1_mode_q    <= s1_mode_d;
            s2_valid_q   <= s2_valid_d;
            s2_p_q       <= s2_p_d;
            s2_id_q      <= s2_id_d;
            s2_mode_q    <= s2_mode_d;
            exact_cnt_q  <= exact_cnt_d;
            approx_cnt_q <= approx_cnt_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_p      = s2_p_q;
    assign out_id     = s2_id_q[0];
    assign out_approx = s2_mode_q;
    assign exact_cnt  = exact_cnt_q;
    assign approx_cnt = approx_cnt_q;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Directed self-checking bench for approx_mul_arbiter.
// Built with N=8, CNT_W=4 so saturation is reachable.
module tb_approx_mul_arbiter;

    localparam int N     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [N-1:0]     req_a0, req_b0, req_a1, req_b1;
    logic [1:0]       req_approx;
    logic [1:0]       mode_cfg;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;
    logic             out_id;
    logic             out_approx;
    logic             clr_cnt;
    logic [CNT_W-1:0] exact_cnt, approx_cnt;

    int checks = 0;
    int errors = 0;
    int acc;

    approx_mul_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_approx (req_approx),
        .mode_cfg   (mode_cfg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_p      (out_p),
        .out_id     (out_id),
        .out_approx (out_approx),
        .clr_cnt    (clr_cnt),
        .exact_cnt  (exact_cnt),
        .approx_cnt (approx_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_approx = 2'b00;
        mode_cfg = 2'b00; out_ready = 1'b1; clr_cnt = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_p", 32'(out_p), 32'h0);
        check("rst_cnts", {exact_cnt, approx_cnt}, 32'h0);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        step(); step();
        rst = 1'b0;

        // exact, requester 0
        req_valid = 2'b01; req_a0 = 8'hB7; req_b0 = 8'h5C;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check("t1_lat1", 32'(out_valid), 32'h0);
        step();
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_p", 32'(out_p), 32'h41C4);
        check("t1_id", 32'(out_id), 32'h0);
        check("t1_apx", 32'(out_approx), 32'h0);
        step();
        check("t1_ecnt", 32'(exact_cnt), 32'h1);
        check("t1_drain", 32'(out_valid), 32'h0);

        // approximate, requester 0
        req_valid = 2'b01; req_approx = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        check("t2_p", 32'(out_p), 32'h3700);
        check("t2_apx", 32'(out_approx), 32'h1);
        step();
        check("t2_acnt", 32'(approx_cnt), 32'h1);

        // alternating grants from a fresh reset
        rst = 1'b1; #1; rst = 1'b0;
        req_approx = 2'b00;
        req_a0 = 8'd2; req_b0 = 8'd3; req_a1 = 8'd5; req_b1 = 8'd7;
        req_valid = 2'b11;
        for (int j = 0; j < 6; j++) begin
            #1;
            check("t3_grant", 32'(req_ready), (j % 2 == 0) ? 32'h1 : 32'h2);
            step();
            if (j >= 1) begin
                check("t3_id", 32'(out_id), 32'((j - 1) % 2));
                check("t3_p", 32'(out_p), ((j - 1) % 2 == 0) ? 32'd6 : 32'd35);
            end
        end
        req_valid = 2'b00;
        step();
        check("t3_last_p", 32'(out_p), 32'd35);
        step();
        check("t3_ecnt", 32'(exact_cnt), 32'd6);

        // backpressure
        out_ready = 1'b0;
        req_a0 = 8'h10; req_b0 = 8'h10; req_a1 = 8'h20; req_b1 = 8'h03;
        req_valid = 2'b11;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            acc += $countones(req_valid & req_ready);
            step();
            if (i >= 1) check("t4_hold_p", 32'(out_p), 32'h100);
        end
        check("t4_accepts", 32'(acc), 32'd2);
        #1;
        check("t4_stall", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        out_ready = 1'b1;
        check("t4_r0_id", 32'(out_id), 32'h0);
        step();
        check("t4_r1_p", 32'(out_p), 32'h60);
        check("t4_r1_id", 32'(out_id), 32'h1);
        step();
        check("t4_empty", 32'(out_valid), 32'h0);

        // forced exact
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        mode_cfg = 2'b10; req_approx = 2'b11;
        req_a0 = 8'hFF; req_b0 = 8'hFF;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        check("t5_p", 32'(out_p), 32'hFE01);
        check("t5_apx", 32'(out_approx), 32'h0);
        step();
        check("t5_ecnt", 32'(exact_cnt), 32'h1);

        // forced approximate
        mode_cfg = 2'b01;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        check("t6_p", 32'(out_p), 32'hE100);
        check("t6_apx", 32'(out_approx), 32'h1);
        step();
        check("t6_acnt", 32'(approx_cnt), 32'h1);

        // saturation of approx_cnt
        req_valid = 2'b01;
        for (int i = 0; i < 17; i++) step();
        req_valid = 2'b00;
        step(); step();
        check("t7_sat", 32'(approx_cnt), 32'hF);
        check("t7_ecnt", 32'(exact_cnt), 32'h1);

        // clear on a completion cycle
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();
        check("t8_pre", 32'(out_valid), 32'h1);
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
        check("t8_clr", 32'(approx_cnt), 32'h0);

        // reset while both stages are full
        out_ready = 1'b0;
        req_valid = 2'b01;
        step(); step();
        check("t9_full", 32'(out_valid), 32'h1);
        check("t9_stall", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("t9_async", 32'(out_valid), 32'h0);
        step();
        rst = 1'b0;
        req_valid = 2'b00;
        out_ready = 1'b1;
        step();
        check("t9_nostale", 32'(out_valid), 32'h0);
        req_valid = 2'b11;
        #1;
        check("t9_ptr", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/approx_mul_arbiter.md
Name: approx_mul_arbiter

Overview:
- Two-requester arbiter and pipeline controller that shares one hybrid multiplier datapath between requesters.
- Each request selects an exact product or an approximate product; the approximate product uses the upper-half operand multiply with the lower N bits zeroed.
- A round-robin grant feeds a 2-stage valid/ready pipeline. The result is tagged with the requester ID.
- Saturating activity counters report exact and approximate usage for power accounting.

Parameters:
- N, 8, operand width. Must be even and ≥4; the approximate path uses bits [N-1:N/2].
- CNT_W, 16, width of each usage counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; handshake completes on valid&ready.
- req_a0, req_b0  in  N each  requester 0 operands.
- req_a1, req_b1  in  N each  requester 1 operands.
- req_approx  in  2  per-requester mode: 1 = approximate, 0 = exact.
- mode_cfg  in  2  00 per-request, 01 force approximate, 10 force exact, 11 treated as 00.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_p  out  2N  product.
- out_id  out  1  requester that issued the result.
- out_approx  out  1  1 if out_p is the approximate product.
- clr_cnt  in  1  synchronous counter clear.
- exact_cnt, approx_cnt  out  CNT_W each  completed-operation counters.

Behaviour:
- Reset (async assert, sync-free release): all of the following go to 0.
  - s1_valid, s2_valid, out_valid, out_p, out_id, out_approx.
  - Both counters.
  - RR priority pointer (requester 0 has priority first).
  - req_ready.
- Stage enables:
  - s2_load = s1_valid & (!s2_valid | out_ready).
  - s1_load = !s1_valid | s2_load.
- Arbitration (combinational):
  - If both req_valid bits are high, grant goes to the priority pointer.
  - Otherwise grant goes to whichever single requester is valid.
  - req_ready[i] = grant[i] & s1_load. At most one bit is high. req_ready never depends on the other requester's ready.
- Pointer update: on an accepted handshake from i, the pointer moves to 1-i. With no accept it holds.
- Effective mode, resolved at accept time and registered in S1: mode_cfg 01 → 1; 10 → 0; else req_approx[i].
- S1 registers A, B, id and mode. S2 registers P, id and mode.
  - Exact: P = A*B, full 2N bits.
  - Approximate: P = {A[N-1:N/2]*B[N-1:N/2], N'b0}.
- Latency: a request accepted at edge k gives out_valid high after edge k+1. Throughput is 1 result/cycle when out_ready stays high.
- Backpressure:
  - While out_valid & !out_ready, all S2 outputs hold stable.
  - If S1 is also full, req_ready = 0.
  - No result is ever dropped or duplicated.
- If S2 drains and S1 refills on the same edge, both transfers happen.
- mode_cfg changes take effect only for requests accepted after the change. In-flight entries keep their registered mode.
- Counters:
  - On out_valid & out_ready, increment approx_cnt if out_approx, else exact_cnt.
  - Counters saturate at all-ones.
  - clr_cnt zeroes both counters and has priority over a same-cycle increment.
- Reset mid-operation flushes both stages. No partial result appears after release.
- req_valid with unstable operands is the requester's error. Operands are sampled only on handshake.

Decomposition:
- Shared package holds:
  - MODE_PER_REQ/FORCE_APPROX/FORCE_EXACT constants (2'b00/01/10).
  - The requester ID width constant.
- One sub-module: hybrid_mul_core. It is combinational A, B, approx → P, with N-parametrized exact and approximate paths. S2 captures its output.
- Arbiter and pipeline control stay in the top module.

Test Plan:
- N=8, out_ready=1, requester 0 only, A=0xB7, B=0x5C:
  - approx=0 → out_p=0x41C4, out_id=0, out_valid two edges after accept.
  - approx=1 → out_p=0x3700.
- Both requesters valid continuously for 6 cycles → grants alternate 0,1,0,1,0,1. exact_cnt=6 after drain.
- out_ready held low 5 cycles with both requesters valid:
  - Exactly 2 requests accepted, then req_ready=0.
  - out_p stable throughout.
  - Release gives results in accept order, none lost.
- mode_cfg=10 with req_approx=2'b11, A=B=0xFF → out_p=0xFE01, out_approx=0, exact_cnt increments.
- mode_cfg=01 on the same stimulus → out_p=0xE100 (0xF*0xF=0xE1), approx_cnt increments.
- Counters:
  - Preload approx_cnt via 2^CNT_W completions (CNT_W=4 build): the counter holds at 0xF.
  - clr_cnt asserted on the same cycle as a completion → counter reads 0.
- Assert rst while both stages are full → out_valid drops immediately (async). After release there is no stale result, and the pointer is back at requester 0.
